// File: rtl/ss_pkg.sv
// ----------------------------------------------------------------------------
// ss_pkg
// Shared types and constants for the seven-segment scan controller.
//   slot_state_e : phase of the current digit slot (guard / on / off)
//   SEG_TABLE    : hex nibble -> active-high segments, bit order {g,f,e,d,c,b,a}
//   SEG_OFF      : active-high "no segment lit" pattern
// ----------------------------------------------------------------------------
package ss_pkg;

   typedef enum logic [1:0] {
      ST_GUARD = 2'd0,
      ST_ON    = 2'd1,
      ST_OFF   = 2'd2
   } slot_state_e;

   localparam logic [6:0] SEG_OFF = 7'b000_0000;

   // 0 1 2 3 4 5 6 7 8 9 A b C d E F
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/ss_scan_controller_hex_decoder.sv
// ----------------------------------------------------------------------------
// ss_hex_decoder
// Combinational hex nibble to seven-segment decoder (active-high output).
// Output polarity is handled by the caller.
//   i_nibble : hex digit 0..F
//   o_seg    : segments {g,f,e,d,c,b,a}, 1 = lit
// ----------------------------------------------------------------------------
module ss_hex_decoder
   import ss_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   // Table lookup of the segment pattern for the nibble.
   always_comb begin
      o_seg = SEG_TABLE[i_nibble];
   end

endmodule

// File: rtl/ss_scan_controller.sv
// ----------------------------------------------------------------------------
// ss_scan_controller
// N-digit common-anode seven-segment scan controller with frame-synchronous
// input snapshot, per-digit dp and blank, leading-zero suppression, PWM
// brightness and an all-anodes-off guard interval at the start of every slot.
//   clk_i, reset_i   : clock, asynchronous active-low reset
//   scan_tick_i      : scan enable; every timing counter advances on it
//   bin_i            : hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_i, blank_i    : per-digit decimal point / force-dark
//   lzs_en_i         : leading-zero suppression enable
//   brightness_i     : on-ticks per slot (0 = dark)
//   anode_bits_o     : digit enables
//   cathode_bits_o   : segments {g,f,e,d,c,b,a}
//   dp_o             : decimal point segment
//   frame_o          : one-cycle pulse when a new frame (snapshot) starts
// ----------------------------------------------------------------------------
module ss_scan_controller
   import ss_pkg::*;
#(
   parameter int NUM_DIGITS         = 4,
   parameter int BRIGHT_W           = 3,
   parameter int GUARD_TICKS        = 1,
   parameter int ANODE_ACTIVE_LOW   = 1,
   parameter int CATHODE_ACTIVE_LOW = 1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      scan_tick_i,
   input  logic [4*NUM_DIGITS-1:0]   bin_i,
   input  logic [NUM_DIGITS-1:0]     dp_i,
   input  logic [NUM_DIGITS-1:0]     blank_i,
   input  logic                      lzs_en_i,
   input  logic [BRIGHT_W-1:0]       brightness_i,
   output logic [NUM_DIGITS-1:0]     anode_bits_o,
   output logic [6:0]                cathode_bits_o,
   output logic                      dp_o,
   output logic                      frame_o
);

   localparam int SLOT_TICKS = GUARD_TICKS + (1 << BRIGHT_W);
   localparam int T_W        = $clog2(SLOT_TICKS);
   localparam int D_W        = $clog2(NUM_DIGITS);

   localparam logic [T_W-1:0] T_LAST  = T_W'(SLOT_TICKS - 1);
   localparam logic [T_W-1:0] T_GUARD = T_W'(GUARD_TICKS);
   localparam logic [T_W-1:0] T_ONE   = T_W'(1);
   localparam logic [T_W-1:0] T_ZERO  = {T_W{1'b0}};
   localparam logic [D_W-1:0] D_LAST  = D_W'(NUM_DIGITS - 1);
   localparam logic [D_W-1:0] D_ONE   = D_W'(1);
   localparam logic [D_W-1:0] D_ZERO  = {D_W{1'b0}};

   // Physical "inactive" levels; xor with these turns logical into pin levels.
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
      (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [6:0] CATH_OFF = (CATHODE_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF   = (CATHODE_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [1:0]                r_rst_sync;
   logic                      w_rst_n;
   logic                      r_started, w_started_nxt;
   logic [D_W-1:0]            r_d, w_d_nxt;
   logic [T_W-1:0]            r_t, w_t_nxt;
   logic [T_W-1:0]            w_k;
   logic [T_W-1:0]            w_br_ext;
   logic                      w_snap;
   slot_state_e               r_state, w_state_nxt;
   logic [4*NUM_DIGITS-1:0]   r_bin, w_bin_nxt;
   logic [NUM_DIGITS-1:0]     r_dp, w_dp_nxt;
   logic [NUM_DIGITS-1:0]     r_blank, w_blank_nxt;
   logic                      r_lzs, w_lzs_nxt;
   logic [BRIGHT_W-1:0]       r_br, w_br_nxt;
   logic [NUM_DIGITS-1:0]     w_supp;
   logic                      w_zero_above;
   logic [3:0]                w_nib;
   logic [6:0]                w_seg;
   logic                      w_on;
   logic [NUM_DIGITS-1:0]     w_anode_log;
   logic [6:0]                w_cath_log;
   logic                      w_dp_log;
   logic [NUM_DIGITS-1:0]     r_anode;
   logic [6:0]                r_cath;
   logic                      r_dp_out;
   logic                      r_frame;

   // Reset synchroniser: assertion is immediate, release is aligned to clk.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rst_sync <= 2'b00;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_n = r_rst_sync[1];

   // Digit/tick counters; the first tick after reset opens frame 0 in place.
   always_comb begin
      w_started_nxt = r_started;
      w_d_nxt       = r_d;
      w_t_nxt       = r_t;
      w_snap        = 1'b0;
      if (scan_tick_i) begin
         if (!r_started) begin
            w_started_nxt = 1'b1;
            w_d_nxt       = D_ZERO;
            w_t_nxt       = T_ZERO;
            w_snap        = 1'b1;
         end else if (r_t == T_LAST) begin
            w_t_nxt = T_ZERO;
            if (r_d == D_LAST) begin
               w_d_nxt = D_ZERO;
               w_snap  = 1'b1;
            end else begin
               w_d_nxt = r_d + D_ONE;
            end
         end else begin
            w_t_nxt = r_t + T_ONE;
         end
      end else begin
         w_snap = 1'b0;
      end
   end

   // Shadow values as they will be after this cycle (used for output lookahead).
   assign w_bin_nxt   = w_snap ? bin_i        : r_bin;
   assign w_dp_nxt    = w_snap ? dp_i         : r_dp;
   assign w_blank_nxt = w_snap ? blank_i      : r_blank;
   assign w_lzs_nxt   = w_snap ? lzs_en_i     : r_lzs;
   assign w_br_nxt    = w_snap ? brightness_i : r_br;

   assign w_k      = w_t_nxt - T_GUARD;
   assign w_br_ext = {{(T_W - BRIGHT_W){1'b0}}, w_br_nxt};

   // Slot FSM next state: GUARD -> ON (if brightness) -> OFF -> GUARD of next digit.
   always_comb begin
      w_state_nxt = r_state;
      if (scan_tick_i) begin
         case (r_state)
            ST_GUARD: begin
               if (w_t_nxt < T_GUARD)      w_state_nxt = ST_GUARD;
               else if (w_k < w_br_ext)    w_state_nxt = ST_ON;
               else                        w_state_nxt = ST_OFF;
            end
            ST_ON: begin
               if (w_t_nxt == T_ZERO)      w_state_nxt = ST_GUARD;
               else if (w_k < w_br_ext)    w_state_nxt = ST_ON;
               else                        w_state_nxt = ST_OFF;
            end
            ST_OFF: begin
               if (w_t_nxt == T_ZERO)      w_state_nxt = ST_GUARD;
               else                        w_state_nxt = ST_OFF;
            end
            default: w_state_nxt = ST_GUARD;
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // Leading-zero mask: digit i is suppressed when nibbles i..top are all zero.
   always_comb begin
      w_zero_above = 1'b1;
      w_supp       = {NUM_DIGITS{1'b0}};
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         w_zero_above = w_zero_above & (w_bin_nxt[4*i +: 4] == 4'h0);
         w_supp[i]    = w_lzs_nxt & w_zero_above & (i != 0);
      end
   end

   assign w_nib = w_bin_nxt[{w_d_nxt, 2'b00} +: 4];

   ss_hex_decoder u_dec (
      .i_nibble (w_nib),
      .o_seg    (w_seg)
   );

   // Anode and segments are driven together, only while the digit is ON and visible.
   assign w_on = (w_state_nxt == ST_ON) & ~w_blank_nxt[w_d_nxt] & ~w_supp[w_d_nxt];
   assign w_anode_log = w_on ? ({{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_d_nxt)
                             : {NUM_DIGITS{1'b0}};
   assign w_cath_log  = w_on ? w_seg : SEG_OFF;
   assign w_dp_log    = w_on & w_dp_nxt[w_d_nxt];

   // Counter, FSM state and shadow registers.
   always_ff @(posedge clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_started <= 1'b0;
         r_d       <= D_ZERO;
         r_t       <= T_ZERO;
         r_state   <= ST_GUARD;
         r_bin     <= {(4*NUM_DIGITS){1'b0}};
         r_dp      <= {NUM_DIGITS{1'b0}};
         r_blank   <= {NUM_DIGITS{1'b0}};
         r_lzs     <= 1'b0;
         r_br      <= {BRIGHT_W{1'b0}};
      end else begin
         r_started <= w_started_nxt;
         r_d       <= w_d_nxt;
         r_t       <= w_t_nxt;
         r_state   <= w_state_nxt;
         r_bin     <= w_bin_nxt;
         r_dp      <= w_dp_nxt;
         r_blank   <= w_blank_nxt;
         r_lzs     <= w_lzs_nxt;
         r_br      <= w_br_nxt;
      end
   end

   // Output registers; polarity is applied here and nowhere else.
   always_ff @(posedge clk_i or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_anode  <= ANODE_OFF;
         r_cath   <= CATH_OFF;
         r_dp_out <= DP_OFF;
         r_frame  <= 1'b0;
      end else begin
         r_frame <= w_snap;
         if (scan_tick_i) begin
            r_anode  <= w_anode_log ^ ANODE_OFF;
            r_cath   <= w_cath_log ^ CATH_OFF;
            r_dp_out <= w_dp_log ^ DP_OFF;
         end else begin
            r_anode  <= r_anode;
            r_cath   <= r_cath;
            r_dp_out <= r_dp_out;
         end
      end
   end

   assign anode_bits_o   = r_anode;
   assign cathode_bits_o = r_cath;
   assign dp_o           = r_dp_out;
   assign frame_o        = r_frame;

endmodule

// File: tb/tb_ss_scan_controller.sv
// ----------------------------------------------------------------------------
// tb_ss_scan_controller
// Self-checking bench: 4 digits, BRIGHT_W=2, GUARD_TICKS=1 (5-tick slot,
// 20-tick frame). Expected outputs come from a tick-count model: the frame
// position is (ticks since start) mod 20, from which digit, slot tick,
// visibility and segment pattern are computed directly.
// ----------------------------------------------------------------------------
module tb_ss_scan_controller;

   localparam int N     = 4;
   localparam int BW    = 2;
   localparam int G     = 1;
   localparam int SLOT  = G + (1 << BW);
   localparam int FRAME = N * SLOT;

   logic          clk_i = 1'b0;
   logic          reset_i = 1'b0;
   logic          scan_tick_i = 1'b0;
   logic [15:0]   bin_i = 16'h0000;
   logic [3:0]    dp_i = 4'h0;
   logic [3:0]    blank_i = 4'h0;
   logic          lzs_en_i = 1'b0;
   logic [1:0]    brightness_i = 2'd0;
   logic [3:0]    anode_bits_o;
   logic [6:0]    cathode_bits_o;
   logic          dp_o;
   logic          frame_o;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit          m_started = 1'b0;
   int          m_n = 0;
   logic [15:0] m_bin;
   logic [3:0]  m_dp, m_blank;
   logic        m_lzs;
   logic [1:0]  m_br;
   logic [3:0]  e_anode = 4'hF;
   logic [6:0]  e_cath = 7'h7F;
   logic        e_dp = 1'b1;
   logic        e_frame = 1'b0;

   logic [6:0] seg_tab [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   ss_scan_controller #(
      .NUM_DIGITS(N), .BRIGHT_W(BW), .GUARD_TICKS(G),
      .ANODE_ACTIVE_LOW(1), .CATHODE_ACTIVE_LOW(1)
   ) dut (
      .clk_i(clk_i), .reset_i(reset_i), .scan_tick_i(scan_tick_i),
      .bin_i(bin_i), .dp_i(dp_i), .blank_i(blank_i), .lzs_en_i(lzs_en_i),
      .brightness_i(brightness_i), .anode_bits_o(anode_bits_o),
      .cathode_bits_o(cathode_bits_o), .dp_o(dp_o), .frame_o(frame_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t, tick#%0d)", tag, obs, exp, $time, m_n);
      end
   endtask

   task automatic check_outs();
      check_val("anode", 32'(anode_bits_o), 32'(e_anode));
      check_val("cathode", 32'(cathode_bits_o), 32'(e_cath));
      check_val("dp", 32'(dp_o), 32'(e_dp));
      check_val("frame", 32'(frame_o), 32'(e_frame));
   endtask

   // One clock with the given tick level; advance the model, then compare.
   task automatic step(input logic tick);
      int p, d, t;
      bit vis, on;
      logic [3:0] one;
      scan_tick_i = tick;
      @(posedge clk_i);
      #1;
      e_frame = 1'b0;
      if (tick) begin
         if (!m_started) begin
            m_started = 1'b1;
            m_n = 0;
         end else begin
            m_n++;
         end
         p = m_n % FRAME;
         if (p == 0) begin
            m_bin = bin_i; m_dp = dp_i; m_blank = blank_i;
            m_lzs = lzs_en_i; m_br = brightness_i;
            e_frame = 1'b1;
         end
         d = p / SLOT;
         t = p % SLOT;
         vis = !m_blank[d] && !(m_lzs && d != 0 && (m_bin >> (4*d)) == 16'h0000);
         on  = vis && (t >= G) && ((t - G) < int'(m_br));
         one = 4'b0001;
         e_anode = on ? ~(one << d) : 4'hF;
         e_cath  = on ? ~seg_tab[m_bin[4*d +: 4]] : 7'h7F;
         e_dp    = on ? ~m_dp[d] : 1'b1;
      end
      check_outs();
   endtask

   task automatic run_ticks(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         step(1'b1);
         for (int j = 0; j < gap; j++) step(1'b0);
      end
   endtask

   // Asynchronous reset between clock edges; outputs must drop at once.
   task automatic do_reset();
      #3 reset_i = 1'b0;
      #1;
      m_started = 1'b0;
      e_anode = 4'hF; e_cath = 7'h7F; e_dp = 1'b1; e_frame = 1'b0;
      check_outs();
      step(1'b0);
      step(1'b0);
      #2 reset_i = 1'b1;
      step(1'b0);
      step(1'b0);
      step(1'b0);
   endtask

   initial begin
      #2;
      do_reset();

      // "1234" at brightness 3, tick held high
      bin_i = 16'h1234; brightness_i = 2'd3;
      step(1'b1);
      check_val("t0_anode_guard", 32'(anode_bits_o), 32'h0000000F);
      check_val("t0_frame", 32'(frame_o), 32'h00000001);
      step(1'b1);
      check_val("t1_anode_on", 32'(anode_bits_o), 32'h0000000E);
      check_val("t1_cathode_4", 32'(cathode_bits_o), 32'h00000019);
      step(1'b1);
      do_reset();                      // mid-slot with anode 1110

      run_ticks(2 * FRAME, 1);          // with idle cycles between ticks
      lzs_en_i = 1'b1; bin_i = 16'h0070;
      run_ticks(2 * FRAME, 0);
      bin_i = 16'h0000;
      run_ticks(2 * FRAME, 0);
      lzs_en_i = 1'b0; bin_i = 16'h1111;
      run_ticks(FRAME + 2 * SLOT, 0);   // now inside slot 2
      bin_i = 16'h2222;
      run_ticks(2 * FRAME, 0);
      brightness_i = 2'd0;
      run_ticks(2 * FRAME, 0);
      brightness_i = 2'd3; dp_i = 4'b0010; blank_i = 4'b1000;
      run_ticks(2 * FRAME, 2);

      // randomized inputs and tick pattern
      for (int i = 0; i < 1500; i++) begin
         logic [15:0] r;
         r = 16'($urandom);
         bin_i        = r >> (4 * $urandom_range(0, 4));
         dp_i         = 4'($urandom);
         blank_i      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
         lzs_en_i     = 1'($urandom);
         brightness_i = 2'($urandom);
         if (i == 700) do_reset();
         step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
